// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI peripheral between two requesters using round-robin grants and fixed-length transfer timing.
// Optional feature macro SPI_ARB_LOCK_EN adds lock0/lock1 so the owner can keep the SPI for multi-byte frames.
module spi_arbiter #(
  parameter int XFER_CYCLES = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clkin,
  input  logic       rst,
`ifdef SPI_ARB_LOCK_EN
  input  logic       lock0,
  input  logic       lock1,
`endif
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       load,
  output logic       unload,
  output logic [7:0] datain,
  input  logic [7:0] dataout,
  output logic       busy,
  output logic       owner
);

  // Handshake: a requester holds req (with stable we/wdata) until it sees its ack,
  // a one-cycle pulse in DONE; it must drop req on that edge to avoid a second grant.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic             grant_vld;
  logic             grant_id;
  logic             xfer_last;
`ifdef SPI_ARB_LOCK_EN
  logic             lock_hold_q;
`endif

  assign xfer_last = (cnt_q == CNT_W'(XFER_CYCLES - 1));

  // owner doubles as last_grant: both always name the most recent grantee.
  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_id  = owner;
    case (state_q)
      IDLE: begin
`ifdef SPI_ARB_LOCK_EN
        if (lock_hold_q && (owner ? req1 : req0)) begin
          grant_vld = 1'b1;
          grant_id  = owner;
        end else
`endif
        if (req0 && req1) begin
          grant_vld = 1'b1;
          grant_id  = ~owner;
        end else if (req0) begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end else if (req1) begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
        if (grant_vld) state_d = ISSUE;
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (xfer_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load   = (state_q == ISSUE) && we_q;
  assign unload = (state_q == ISSUE) && !we_q;
  assign ack0   = (state_q == DONE) && !owner;
  assign ack1   = (state_q == DONE) && owner;
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      datain      <= 8'h00;
      rdata       <= 8'h00;
      owner       <= 1'b1;
`ifdef SPI_ARB_LOCK_EN
      lock_hold_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
      // datain doubles as the latched write byte, so later wdata changes cannot reach the SPI.
      if (grant_vld) begin
        owner  <= grant_id;
        we_q   <= grant_id ? we1 : we0;
        datain <= grant_id ? wdata1 : wdata0;
      end
      if ((state_q == WAIT) && xfer_last) rdata <= dataout;
`ifdef SPI_ARB_LOCK_EN
      // Lock only survives into the single IDLE cycle right after DONE.
      lock_hold_q <= (state_q == DONE) && (owner ? lock1 : lock0);
`endif
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed bench with a transaction-level model checked every cycle, plus literal checks.
// Build with SPI_ARB_LOCK_EN defined to also exercise the lock feature.
module tb_spi_arbiter;
  localparam int XFER = 16;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00, dataout = 8'h00;
  logic       ack0, ack1, load, unload, busy, owner;
  logic [7:0] rdata, datain;
`ifdef SPI_ARB_LOCK_EN
  logic       lock0 = 1'b0, lock1 = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  spi_arbiter #(.XFER_CYCLES(XFER), .CNT_W(5)) dut (
    .clkin(clkin), .rst(rst),
`ifdef SPI_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .req0(req0), .we0(we0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .load(load), .unload(unload), .datain(datain),
    .dataout(dataout), .busy(busy), .owner(owner)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: a granted transfer is "active" for XFER+2 cycles counted from the grant edge.
  bit         m_active = 1'b0;
  int         m_pos = 0;
  bit         m_owner = 1'b1;
  bit         m_we = 1'b0;
  logic [7:0] m_wdata = 8'h00;
  logic [7:0] m_rdata = 8'h00;
  bit         m_lock = 1'b0;

  always @(posedge clkin) begin
    int g;
    bit lock_now;
    cyc++;
    if (rst) begin
      m_active = 1'b0; m_pos = 0; m_owner = 1'b1; m_rdata = 8'h00; m_lock = 1'b0;
    end else if (!m_active) begin
      lock_now = m_lock;
      m_lock   = 1'b0;
      g = -1;
      if (lock_now && (m_owner ? req1 : req0)) g = int'(m_owner);
      else if (req0 && req1) g = m_owner ? 0 : 1;
      else if (req0) g = 0;
      else if (req1) g = 1;
      if (g >= 0) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_owner  = (g == 1);
        m_we     = (g == 1) ? we1 : we0;
        m_wdata  = (g == 1) ? wdata1 : wdata0;
      end
    end else begin
      m_pos++;
      if (m_pos == XFER + 1) m_rdata = dataout;
      if (m_pos == XFER + 2) begin
        m_active = 1'b0;
`ifdef SPI_ARB_LOCK_EN
        m_lock = m_owner ? lock1 : lock0;
`endif
      end
    end
  end

  always @(negedge clkin) begin
    check("busy", busy, m_active);
    check("load", load, m_active && m_pos == 0 && m_we);
    check("unload", unload, m_active && m_pos == 0 && !m_we);
    check("ack0", ack0, m_active && m_pos == XFER + 1 && !m_owner);
    check("ack1", ack1, m_active && m_pos == XFER + 1 && m_owner);
    check("owner", owner, m_owner);
    check("rdata", rdata, m_rdata);
    if (m_active && m_pos == 0) check("datain", datain, m_wdata);
  end

  task automatic wait_strobe(output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clkin);
      if (load || unload) begin at = cyc; ok = 1'b1; break; end
    end
    if (!ok) check("strobe_timeout", 0, 1);
  endtask

  task automatic wait_ack(input bit which, output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clkin);
      if (which ? ack1 : ack0) begin at = cyc; ok = 1'b1; break; end
    end
    if (!ok) check("ack_timeout", 0, 1);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         strobe_q[$];

  initial begin
    int  g_at, a_at, n, stray;
    bit  ok;

    // reset
    repeat (2) @(negedge clkin);
    check("reset_busy", busy, 0);
    check("reset_owner", owner, 1);
    check("reset_rdata", rdata, 8'h00);
    check("reset_strobe", {load, unload, ack0, ack1}, 4'b0000);
    rst = 1'b0;

    // single write from requester 0
    req0 = 1'b1; we0 = 1'b1; wdata0 = 8'hA5; dataout = 8'h5E;
    wait_strobe(g_at, ok);
    check("w_load", load, 1);
    check("w_datain", datain, 8'hA5);
    wait_ack(1'b0, a_at, ok);
    req0 = 1'b0;
    check("w_latency", a_at + 1 - g_at, 18);
    check("w_ack1", ack1, 0);
    check("w_rdata", rdata, 8'h5E);

    // single read from requester 1
    @(negedge clkin);
    dataout = 8'h3C; req1 = 1'b1; we1 = 1'b0;
    wait_strobe(g_at, ok);
    check("r_unload", unload, 1);
    wait_ack(1'b1, a_at, ok);
    req1 = 1'b0;
    check("r_rdata", rdata, 8'h3C);
    check("r_owner", owner, 1);

    // contention: both held, each drops req on its ack and re-raises next cycle
    @(negedge clkin);
    exp_q = '{8'd0, 8'd1, 8'd0, 8'd1};
    got_q.delete(); strobe_q.delete();
    we0 = 1'b1; wdata0 = 8'h21; we1 = 1'b0; dataout = 8'h44;
    req0 = 1'b1; req1 = 1'b1; n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clkin);
      if (load || unload) strobe_q.push_back(cyc);
      if (ack0) begin got_q.push_back(8'd0); n++; req0 = 1'b0; end else req0 = 1'b1;
      if (ack1) begin got_q.push_back(8'd1); n++; req1 = 1'b0; end else req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("c_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("c_order", got_q[i], exp_q[i]);
    for (int i = 1; i < strobe_q.size(); i++)
      check("c_gap_ge19", (strobe_q[i] - strobe_q[i-1]) >= 19, 1);

    // withdrawal: requester 0 pulses req for one cycle while requester 1 is in WAIT
    @(negedge clkin);
    req1 = 1'b1; we1 = 1'b1; wdata1 = 8'h5A;
    wait_strobe(g_at, ok);
    repeat (3) @(negedge clkin);
    req0 = 1'b1;
    @(negedge clkin);
    req0 = 1'b0;
    wait_ack(1'b1, a_at, ok);
    req1 = 1'b0;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clkin);
      if (ack0 || load || unload) stray++;
    end
    check("wd_no_xfer", stray, 0);
    check("wd_idle", busy, 0);

    // reset during WAIT abandons the transfer
    req0 = 1'b1; we0 = 1'b1; wdata0 = 8'h77;
    wait_strobe(g_at, ok);
    repeat (5) @(negedge clkin);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clkin);
    check("mr_busy", busy, 0);
    check("mr_ack", {ack0, ack1}, 2'b00);
    check("mr_rdata", rdata, 8'h00);
    check("mr_owner", owner, 1);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkin);
      if (ack0 || ack1) stray++;
    end
    check("mr_no_ack", stray, 0);

    // wdata changes after the grant are ignored
    req0 = 1'b1; we0 = 1'b1; wdata0 = 8'h11;
    wait_strobe(g_at, ok);
    wdata0 = 8'hFF; we0 = 1'b0;
    #1;
    check("st_datain", datain, 8'h11);
    check("st_load", load, 1);
    wait_ack(1'b0, a_at, ok);
    req0 = 1'b0;
    check("st_datain_hold", datain, 8'h11);

`ifdef SPI_ARB_LOCK_EN
    // lock: requester 0 served three times back to back, then loses priority
    @(negedge clkin);
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
    got_q.delete();
    we0 = 1'b1; wdata0 = 8'h33; we1 = 1'b1; wdata1 = 8'h66;
    lock0 = 1'b1; req0 = 1'b1;
    wait_strobe(g_at, ok);
    req1 = 1'b1; n = 0;
    for (int i = 0, k = 0; i < 300 && n < 5; i++) begin
      @(negedge clkin);
      if (ack0) begin
        got_q.push_back(8'd0); n++; k++; req0 = 1'b0;
        if (k == 3) lock0 = 1'b0;
      end else req0 = 1'b1;
      if (ack1) begin got_q.push_back(8'd1); n++; req1 = 1'b0; end else req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
    check("lk_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check("lk_order", got_q[i], exp_q[i]);
`endif

    repeat (25) @(negedge clkin);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
endmodule
